// File: rtl/imu_pkg.sv
// Shared types and constants for the IMU burst controller and its output FIFO.
package imu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ADDR,
    READ,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] READ_FLAG = 8'h80;
  localparam int         CH_W      = 3;

  // One address byte followed by every register word of the burst.
  function automatic int burst_bits(input int num_ch, input int data_w);
    return 8 + num_ch * data_w;
  endfunction

endpackage

// File: rtl/imu_msg_fifo.sv
// First-word-fall-through FIFO with a registered head word; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module imu_msg_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_do_pop;
  logic             w_do_push;
  logic [AW-1:0]    w_rd_next;
  logic [AW:0]      w_remain;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign w_rd_next = r_rd + AW'(w_do_pop);
  assign w_remain  = r_count - (AW+1)'(w_do_pop);
  assign o_data    = r_head;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  // The head register is reloaded from the entry that becomes oldest, or
  // bypassed from the input when the FIFO would otherwise be empty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      r_rd    <= w_rd_next;
      r_count <= w_remain + (AW+1)'(w_do_push);
      if (w_remain != '0) r_head <= r_mem[w_rd_next];
      else if (w_do_push) r_head <= i_data;
    end
  end

endmodule

// File: rtl/imu_burst_controller.sv
// SPI mode-0 burst reader: each data-ready edge reads NUM_CH words into a tagged FIFO.
// Optional watchdog pulse on o_timeout is enabled with the IMU_TIMEOUT_EN macro.
module imu_burst_controller
  import imu_pkg::*;
#(
  parameter int         CLK_DIV     = 2,
  parameter int         NUM_CH      = 3,
  parameter int         DATA_W      = 16,
  parameter logic [7:0] BASE_ADDR   = 8'h3B,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         TIMEOUT_CYC = 125000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_data_ready,
  output logic              o_sclk,
  output logic              o_cs_n,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic              o_msg_valid,
  input  logic              i_msg_ready,
  output logic [DATA_W-1:0] o_message,
  output logic [CH_W-1:0]   o_msg_ch,
  output logic              o_overrun,
  output logic              o_timeout
);

  localparam int            TOTAL_BITS = burst_bits(NUM_CH, DATA_W);
  localparam int            CW         = $clog2(2 * CLK_DIV);
  localparam int            WW         = $clog2(DATA_W);
  localparam int            FW         = DATA_W + CH_W;
  localparam logic [CW-1:0] DIV_M1     = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DIV2_M1    = CW'(2 * CLK_DIV - 1);
  localparam logic [7:0]    LAST_BIT   = 8'(TOTAL_BITS - 1);
  localparam logic [WW-1:0] WLAST      = WW'(DATA_W - 1);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [7:0]          r_bit;
  logic [WW-1:0]       r_wbit;
  logic [CH_W-1:0]     r_ch;
  logic [7:0]          r_tx;
  logic [DATA_W-2:0]   r_rx;
  logic                r_sclk;
  logic                r_cs_n;
  logic                r_mosi;
  logic                r_pending;
  logic                r_overrun;
  logic                r_dr_prev;
  logic                r_push;
  logic [DATA_W-1:0]   r_push_word;
  logic [CH_W-1:0]     r_push_ch;

  logic                w_req;
  logic                w_start;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_drop;
  logic [FW-1:0]       w_fifo_dout;

  assign w_req   = i_data_ready && !r_dr_prev;
  assign w_start = i_en && (w_req || r_pending) &&
                   ((r_state == IDLE) || ((r_state == GAP) && (r_cnt == DIV2_M1)));
  assign w_pop   = !w_empty && i_msg_ready;
  assign w_drop  = r_push && w_full && !w_pop;

  assign o_sclk      = r_sclk;
  assign o_cs_n      = r_cs_n;
  assign o_mosi      = r_mosi;
  assign o_msg_valid = !w_empty;
  assign o_message   = w_fifo_dout[DATA_W-1:0];
  assign o_msg_ch    = w_fifo_dout[FW-1:DATA_W];
  assign o_overrun   = r_overrun;

  // Each bit spends CLK_DIV clocks with SCLK low then CLK_DIV high; MISO is
  // captured as SCLK rises and MOSI advances as it falls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_wbit      <= '0;
      r_ch        <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_sclk      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
      r_dr_prev   <= 1'b0;
      r_push      <= 1'b0;
      r_push_word <= '0;
      r_push_ch   <= '0;
    end else begin
      r_dr_prev <= i_data_ready;
      r_push    <= 1'b0;
      if (w_drop) r_overrun <= 1'b1;
      if (!i_en) r_pending <= 1'b0;
      else if (w_req && (r_state != IDLE)) begin
        if (r_pending) r_overrun <= 1'b1;
        else r_pending <= 1'b1;
      end

      if (w_start) begin
        r_state   <= SETUP;
        r_cs_n    <= 1'b0;
        r_sclk    <= 1'b0;
        r_mosi    <= 1'b0;
        r_cnt     <= '0;
        r_bit     <= '0;
        r_wbit    <= '0;
        r_ch      <= '0;
        r_pending <= 1'b0;
        r_tx      <= BASE_ADDR | READ_FLAG;
      end else begin
        case (r_state)
          IDLE: r_cnt <= '0;
          SETUP: begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == DIV_M1) begin
              r_state <= ADDR;
              r_cnt   <= '0;
              r_mosi  <= r_tx[7];
            end
          end
          ADDR, READ: begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == DIV_M1) begin
              r_sclk <= 1'b1;
              if (r_state == READ) begin
                r_rx <= {r_rx[DATA_W-3:0], i_miso};
                if (r_wbit == WLAST) begin
                  r_wbit      <= '0;
                  r_ch        <= r_ch + CH_W'(1);
                  r_push      <= 1'b1;
                  r_push_word <= {r_rx, i_miso};
                  r_push_ch   <= r_ch;
                end else begin
                  r_wbit <= r_wbit + WW'(1);
                end
              end
            end else if (r_cnt == DIV2_M1) begin
              r_sclk <= 1'b0;
              r_cnt  <= '0;
              r_bit  <= r_bit + 8'd1;
              r_tx   <= {r_tx[6:0], 1'b0};
              r_mosi <= r_tx[6];
              if (r_bit == LAST_BIT) begin
                r_state <= HOLD;
                r_mosi  <= 1'b0;
              end else if (r_bit == 8'd7) begin
                r_state <= READ;
              end
            end
          end
          HOLD: begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == DIV_M1) begin
              r_state <= GAP;
              r_cs_n  <= 1'b1;
              r_cnt   <= '0;
            end
          end
          GAP: begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == DIV2_M1) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  imu_msg_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_push),
    .i_data  ({r_push_ch, r_push_word}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef IMU_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_timeout;

  // Watchdog restarts on every request so it only fires when the IMU goes quiet.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en || w_req) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (r_to_cnt == 32'(TIMEOUT_CYC - 1)) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b1;
    end else begin
      r_to_cnt  <= r_to_cnt + 32'd1;
      r_timeout <= 1'b0;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_imu_burst_controller.sv
// Directed bench for imu_burst_controller with an SPI slave model and a FIFO-drain monitor.
module tb_imu_burst_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        dataReady = 1'b0;
  logic        msgReady = 1'b0;
  logic        sclk;
  logic        csN;
  logic        mosi;
  logic        miso;
  logic        msgValid;
  logic [15:0] message;
  logic [2:0]  msgCh;
  logic        overrun;
  logic        timeout;

  int passCount = 0;
  int checkCount = 0;
  int failCount = 0;

  localparam logic [55:0] FRAME_BITS = {8'h00, 16'h1234, 16'hABCD, 16'h0F0F};
  logic [55:0] frameBits = FRAME_BITS;

  int          slvIdx = 0;
  int          mosiCnt = 0;
  logic [7:0]  addrByte = 8'h00;
  logic        prevCs = 1'b1;
  logic        prevSclk = 1'b0;
  int          csLowCnt = 0;
  int          csHighCnt = 0;
  int          lastLowLen = 0;
  int          lastHighLen = 0;
  int          burstCount = 0;
  int          base = 0;
  logic [31:0] rxQ[$];

  imu_burst_controller dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_data_ready (dataReady),
    .o_sclk       (sclk),
    .o_cs_n       (csN),
    .o_mosi       (mosi),
    .i_miso       (miso),
    .o_msg_valid  (msgValid),
    .i_msg_ready  (msgReady),
    .o_message    (message),
    .o_msg_ch     (msgCh),
    .o_overrun    (overrun),
    .o_timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Slave shifts the frame out one bit per SCLK period, advancing on falling edges.
  assign miso = (slvIdx < 56) ? frameBits[6'(55 - slvIdx)] : 1'b0;

  always @(negedge clk) begin
    if (csN) begin
      slvIdx  <= 0;
      mosiCnt <= 0;
      if (!prevCs) begin
        lastLowLen <= csLowCnt;
        csHighCnt  <= 1;
      end else begin
        csHighCnt <= csHighCnt + 1;
      end
    end else begin
      if (prevCs) begin
        burstCount  <= burstCount + 1;
        lastHighLen <= csHighCnt;
        csLowCnt    <= 1;
      end else begin
        csLowCnt <= csLowCnt + 1;
      end
      if (prevSclk && !sclk) slvIdx <= slvIdx + 1;
      if (!prevSclk && sclk && (mosiCnt < 8)) begin
        addrByte <= {addrByte[6:0], mosi};
        mosiCnt  <= mosiCnt + 1;
      end
    end
    prevCs   <= csN;
    prevSclk <= sclk;
    if (msgValid && msgReady && !rst) rxQ.push_back({13'd0, msgCh, message});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] getRx(input int i);
    if (i < rxQ.size()) return rxQ[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then let the given number of clocks pass.
  task automatic applyStimulus(input logic enV, input logic drV, input logic rdyV, input int cycles);
    en        = enV;
    dataReady = drV;
    msgReady  = rdyV;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_sclk", 32'(sclk), 32'd0);
    checkOutput("rst_cs_n", 32'(csN), 32'd1);
    checkOutput("rst_mosi", 32'(mosi), 32'd0);
    checkOutput("rst_valid", 32'(msgValid), 32'd0);
    checkOutput("rst_message", 32'(message), 32'd0);
    checkOutput("rst_msg_ch", 32'(msgCh), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    $display("[TB] single burst, consumer ready");
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 300);
    checkOutput("b1_count", 32'(burstCount), 32'd1);
    checkOutput("b1_cs_low_len", 32'(lastLowLen), 32'd228);
    checkOutput("b1_addr_byte", 32'(addrByte), 32'h0000_00BB);
    checkOutput("b1_words", 32'(rxQ.size()), 32'd3);
    checkOutput("b1_w0", getRx(0), 32'h0000_1234);
    checkOutput("b1_w1", getRx(1), 32'h0001_ABCD);
    checkOutput("b1_w2", getRx(2), 32'h0002_0F0F);
    checkOutput("b1_overrun", 32'(overrun), 32'd0);
    checkOutput("b1_valid_low", 32'(msgValid), 32'd0);

    $display("[TB] two bursts into a stalled FIFO");
    rxQ.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 300);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 300);
    checkOutput("full_valid", 32'(msgValid), 32'd1);
    checkOutput("full_head_word", 32'(message), 32'h0000_1234);
    checkOutput("full_head_ch", 32'(msgCh), 32'd0);
    checkOutput("full_overrun", 32'(overrun), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 12);
    checkOutput("drain_words", 32'(rxQ.size()), 32'd4);
    checkOutput("drain_w0", getRx(0), 32'h0000_1234);
    checkOutput("drain_w1", getRx(1), 32'h0001_ABCD);
    checkOutput("drain_w2", getRx(2), 32'h0002_0F0F);
    checkOutput("drain_w3", getRx(3), 32'h0000_1234);
    checkOutput("drain_valid_low", 32'(msgValid), 32'd0);
    checkOutput("drain_overrun_sticky", 32'(overrun), 32'd1);

    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 2);
    rst = 1'b0;
    checkOutput("rst_clears_overrun", 32'(overrun), 32'd0);

    $display("[TB] requests during a burst");
    rxQ.delete();
    base = burstCount;
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 50);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 50);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 700);
    checkOutput("pend_bursts", 32'(burstCount - base), 32'd2);
    checkOutput("pend_gap_len", 32'(lastHighLen), 32'd4);
    checkOutput("pend_overrun", 32'(overrun), 32'd1);
    checkOutput("pend_words", 32'(rxQ.size()), 32'd6);
    checkOutput("pend_w5", getRx(5), 32'h0002_0F0F);

    $display("[TB] reset in the middle of a burst");
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 110);
    checkOutput("mid_cs_low", 32'(csN), 32'd0);
    checkOutput("mid_valid", 32'(msgValid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_cs_n", 32'(csN), 32'd1);
    checkOutput("abort_sclk", 32'(sclk), 32'd0);
    checkOutput("abort_valid", 32'(msgValid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5);
    rxQ.delete();
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 300);
    checkOutput("clean_cs_low_len", 32'(lastLowLen), 32'd228);
    checkOutput("clean_words", 32'(rxQ.size()), 32'd3);
    checkOutput("clean_w0", getRx(0), 32'h0000_1234);
    checkOutput("clean_w1", getRx(1), 32'h0001_ABCD);
    checkOutput("clean_w2", getRx(2), 32'h0002_0F0F);

    $display("[TB] enable dropped mid-burst");
    rxQ.delete();
    base = burstCount;
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 100);
    applyStimulus(1'b0, 1'b0, 1'b1, 50);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 400);
    checkOutput("en0_bursts", 32'(burstCount - base), 32'd1);
    checkOutput("en0_cs_low_len", 32'(lastLowLen), 32'd228);
    checkOutput("en0_words", 32'(rxQ.size()), 32'd3);
    checkOutput("en0_w2", getRx(2), 32'h0002_0F0F);
    checkOutput("en0_cs_idle", 32'(csN), 32'd1);

`ifndef IMU_TIMEOUT_EN
    checkOutput("timeout_tied_low", 32'(timeout), 32'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/imu_burst_controller.md
Name: imu_burst_controller

Overview:
- Parametrised successor of the single-word IMU controller.
- On each rising edge of the IMU data-ready line, runs one SPI burst read of NUM_CH consecutive DATA_W-bit registers, starting at BASE_ADDR.
- Each received word is pushed, tagged with its channel index, into a small output FIFO that has a valid/ready handshake.
- Sits between the IMU SPI pins and the message/packetiser logic.

Parameters:
CLK_DIV, 2, system clocks per SCLK half-period (>=1)
NUM_CH, 3, registers read per burst (1..8)
DATA_W, 16, bits per register word (8 or 16)
BASE_ADDR, 8'h3B, first register address; read flag 0x80 is ORed in
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)
TIMEOUT_CYC, 125000, watchdog limit in clk cycles (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  enable; bursts start only while high
data_ready  in  1  IMU data-ready, asynchronous to bursts; edge-detected internally
sclk  out  1  SPI clock, CPOL=0
cs_n  out  1  SPI chip select, active-low
mosi  out  1  SPI data out
miso  in  1  SPI data in
msg_valid  out  1  FIFO head valid
msg_ready  in  1  consumer accepts head when msg_valid&&msg_ready
message  out  DATA_W  FIFO head word
msg_ch  out  3  channel index of head word
overrun  out  1  sticky; cleared only by rst
timeout  out  1  single-cycle pulse (optional feature)

Behaviour:
- Reset values: sclk=0, cs_n=1, mosi=0, msg_valid=0, message=0, msg_ch=0, overrun=0, timeout=0. Reset also empties the FIFO, clears the pending request, returns the FSM to IDLE and zeroes the edge-detect register.
- Reset mid-burst: cs_n=1 and sclk=0 from the cycle after rst is sampled high. The partial word is discarded.
- Edge detect: a request is a cycle where data_ready=1 and the registered previous value=0. Single register stage; inputs are assumed already synchronised upstream.
- FSM states:
  - IDLE: cs_n=1. Request && en -> SETUP.
  - SETUP: cs_n=0 for CLK_DIV clocks -> ADDR.
  - ADDR: 8 bits of BASE_ADDR|0x80, MSB first -> READ.
  - READ: NUM_CH*DATA_W bits -> HOLD.
  - HOLD: sclk=0, cs_n=0 for CLK_DIV clocks -> GAP.
  - GAP: cs_n=1 for 2*CLK_DIV clocks -> IDLE.
- SPI timing: mode 0. mosi changes on SCLK falling edges (first bit is driven on entry to ADDR). miso is sampled on SCLK rising edges. Bit period is 2*CLK_DIV clocks. For default parameters, burst length with cs_n low = 2 + 56*4 + 2 = 228 clocks.
- Word completion: on the rising edge that samples the last bit of channel k, the word is pushed in the next cycle with msg_ch=k (k = 0..NUM_CH-1, MSB-first assembly).
- FIFO: first-word fall-through; message and msg_ch are registered.
  - Push and pop in the same cycle is allowed, including when the FIFO is full.
  - Push while full with no pop: word dropped, overrun<=1.
- Request during a non-IDLE state: latched as pending, and the next burst starts immediately after GAP.
  - A second request while pending already set sets overrun<=1 (request is merged).
- en=0 mid-burst: the current burst completes. Pending requests and requests arriving with en=0 are discarded. en=0 never affects the FIFO.
- Request and rst in the same cycle: rst wins.

Optional Feature:
- Macro: IMU_TIMEOUT_EN.
- Defined: a counter runs while en=1. It is cleared by every request, by en=0 and by rst. On reaching TIMEOUT_CYC-1 it pulses timeout=1 for one cycle, then restarts from 0.
- Not defined: timeout is tied to 0, no counter exists, and TIMEOUT_CYC is ignored.

Decomposition:
- Package imu_pkg holds:
  - FSM state enum (IDLE, SETUP, ADDR, READ, HOLD, GAP)
  - READ_FLAG=8'h80
  - CH_W=3
  - function burst_bits(NUM_CH, DATA_W) = 8+NUM_CH*DATA_W
- One sub-module, imu_msg_fifo: synchronous FWFT FIFO parametrised by width (DATA_W+CH_W) and FIFO_DEPTH. It exposes push, pop, full, empty and a data port.
- The SPI shifter and FSM stay in the top module.

Test Plan:
- Defaults; the SPI slave model returns 0x1234, 0xABCD, 0x0F0F, msg_ready=1; one data_ready pulse -> mosi byte 0xBB. Expect three msg_valid pulses, (ch0,0x1234), (ch1,0xABCD), (ch2,0x0F0F), with cs_n low for exactly 228 clocks and overrun=0.
- msg_ready=0, FIFO_DEPTH=4, two bursts (6 words) -> first 4 words retained in order, overrun=1. Then msg_ready=1 -> exactly 4 words drain and msg_valid falls.
- A data_ready edge 50 clocks into a burst -> second burst begins right after GAP (cs_n rises for exactly 4 clocks). A third edge during burst one -> overrun=1, and only 2 bursts run.
- rst pulsed at clock 100 of a burst -> next cycle cs_n=1, sclk=0, msg_valid=0. The next data_ready edge gives a clean burst with correct words.
- en=0 at clock 100 of a burst, with a data_ready edge at clock 150 -> burst completes with 3 words, then no further burst.
- IMU_TIMEOUT_EN defined, TIMEOUT_CYC=1000, en=1, no data_ready -> timeout pulses at clocks 999 and 1999 after en rises. A request at 500 delays the first pulse to 1499.
